// File: rtl/data_ram_mmio_pkg.sv
// rtl/data_ram_mmio_pkg.sv - MMIO offsets and byte-lane merge helper for data_ram_mmio
package data_ram_mmio_pkg;

  // Upper half of the default MMIO window base address.
  localparam logic [15:0] MMIO_BASE_HI = 16'hBFD0;

  // Register offsets inside the MMIO window (addr[15:0]).
  typedef enum logic [15:0] {
    MMIO_GPIO_OFF    = 16'h0000,
    MMIO_COUNT_OFF   = 16'h0004,
    MMIO_COMPARE_OFF = 16'h0008,
    MMIO_STATUS_OFF  = 16'h000C
  } mmio_off_e;

  // Replace byte lane i of old_word with lane i of new_word wherever sel[i] is set;
  // sel[3] covers bits 31:24.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_ram_mmio_timer.sv
// rtl/data_ram_mmio_timer.sv - free-running cycle counter with compare-match pending flag
// Instantiated by data_ram_mmio only when MMIO_TIMER_EN is defined.
module mmio_timer
  import data_ram_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;
  logic        count_we;
  logic        compare_we;
  logic        status_we;
  logic        match;
  logic        clear;

  assign count_we   = wr_en && (offset == MMIO_COUNT_OFF);
  assign compare_we = wr_en && (offset == MMIO_COMPARE_OFF);
  assign status_we  = wr_en && (offset == MMIO_STATUS_OFF);
  // A zero COMPARE disables matching so a freshly reset timer never fires.
  assign match      = (count == compare) && (compare != 32'h0);
  assign clear      = compare_we || (status_we && wdata[0]);

  // Counter advances every cycle; a write loads the new value instead of incrementing.
  always_ff @(posedge clk) begin
    if (rst)           count <= 32'h0;
    else if (count_we) count <= wdata;
    else               count <= count + 32'h1;
  end

  // Compare register is plain read/write storage.
  always_ff @(posedge clk) begin
    if (rst)             compare <= 32'h0;
    else if (compare_we) compare <= wdata;
  end

  // Pending flag: a match in the same cycle as a clear keeps the interrupt asserted.
  always_ff @(posedge clk) begin
    if (rst)        pending <= 1'b0;
    else if (match) pending <= 1'b1;
    else if (clear) pending <= 1'b0;
  end

  // Read mux for the three timer offsets; anything else reads zero.
  always_comb begin
    rdata = 32'h0;
    case (offset)
      MMIO_COUNT_OFF:   rdata = count;
      MMIO_COMPARE_OFF: rdata = compare;
      MMIO_STATUS_OFF:  rdata = {31'h0, pending};
      default:          rdata = 32'h0;
    endcase
  end

  assign irq = pending;

endmodule

// File: rtl/data_ram_mmio.sv
// rtl/data_ram_mmio.sv - data-side word RAM with byte lanes plus GPIO/timer MMIO window
// Timer registers exist only when MMIO_TIMER_EN is defined; otherwise they read 0 and irq is 0.
module data_ram_mmio
  import data_ram_mmio_pkg::*;
#(
  parameter int          RAM_AW    = 17,
  parameter logic [31:0] MMIO_BASE = {MMIO_BASE_HI, 16'h0000},
  parameter int          GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       data_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              timer_irq_o
);

  logic [31:0]       ram [0:(1 << RAM_AW) - 1];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_hit;
  logic [15:0]       offset;
  logic              mmio_wr;
  logic [GPIO_W-1:0] gpio;
  logic [31:0]       gpio_ext;
  logic [31:0]       timer_rdata;

  assign mmio_hit = (addr_i[31:16] == MMIO_BASE[31:16]);
  assign offset   = addr_i[15:0];
  // Upper address bits beyond the RAM index are dropped, so the RAM aliases across the map.
  assign ram_idx  = addr_i[RAM_AW+1:2];
  // MMIO registers only accept full-word writes.
  assign mmio_wr  = ce_i && we_i && mmio_hit && (sel_i == 4'b1111);

  // RAM write port: byte-lane merge, contents survive reset.
  always_ff @(posedge clk) begin
    if (ce_i && we_i && !mmio_hit && !rst) ram[ram_idx] <= lane_merge(ram[ram_idx], data_i, sel_i);
  end

  // GPIO latch.
  always_ff @(posedge clk) begin
    if (rst)                                          gpio <= '0;
    else if (mmio_wr && (offset == MMIO_GPIO_OFF))    gpio <= data_i[GPIO_W-1:0];
  end

  // Zero-extend the GPIO latch for reads.
  always_comb begin
    gpio_ext             = 32'h0;
    gpio_ext[GPIO_W-1:0] = gpio;
  end

`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mmio_wr),
    .offset (offset),
    .wdata  (data_i),
    .rdata  (timer_rdata),
    .irq    (timer_irq_o)
  );
`else
  assign timer_rdata = 32'h0;
  assign timer_irq_o = 1'b0;
`endif

  // Combinational read path; writes and idle cycles drive zero.
  always_comb begin
    data_o = 32'h0;
    if (!rst && ce_i && !we_i) begin
      if (mmio_hit) begin
        if (offset == MMIO_GPIO_OFF) data_o = gpio_ext;
        else                         data_o = timer_rdata;
      end else begin
        data_o = ram[ram_idx];
      end
    end
  end

  assign gpio_o = gpio;

endmodule

// File: tb/tb_data_ram_mmio.sv
// tb/tb_data_ram_mmio.sv - randomized self-checking bench for data_ram_mmio
module tb_data_ram_mmio;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'hBFD0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic [15:0] gpio;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem_m [0:(1 << AW) - 1];
  logic [15:0] gpio_m;
  logic [31:0] cnt_base;
  int          cnt_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_mmio #(.RAM_AW(AW), .MMIO_BASE(BASE), .GPIO_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce),
    .we_i        (we),
    .addr_i      (addr),
    .data_i      (wdata),
    .sel_i       (sel),
    .data_o      (rdata),
    .gpio_o      (gpio),
    .timer_irq_o (irq)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus write beat; the reference model is updated from the bus rules.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [AW-1:0] idx;
    ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(posedge clk);
    #1;
    idx = a[AW+1:2];
    if (!rst) begin
      if (a[31:16] != BASE[31:16]) begin
        for (int b = 0; b < 4; b++) if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end else if (s == 4'hF && a[15:0] == 16'h0000) begin
        gpio_m = d[15:0];
      end else if (s == 4'hF && a[15:0] == 16'h0004) begin
        cnt_base = d;
        cnt_cyc  = cyc;
      end
    end
    ce = 1'b0; we = 1'b0;
  endtask

  // Combinational read sampled mid-cycle, well away from the rising edge.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    #1;
    d = rdata;
    ce = 1'b0;
  endtask

  function automatic logic [31:0] count_model();
    return cnt_base + 32'(cyc - cnt_cyc);
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
    tick(2);
    rst = 1'b0;
    gpio_m = 16'h0; cnt_base = 32'h0; cnt_cyc = cyc;
    checks++; if (gpio !== 16'h0) begin failures++; $display("FAIL reset_gpio got=%h exp=%h", gpio, 16'h0); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    do_read(BASE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_gpio_read got=%h exp=0", d); end
    addr = 32'h100; ce = 1'b0; we = 1'b0; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_idle_read got=%h exp=0", rdata); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    do_write(32'h100, 32'h1122_3344, 4'b1111);
    do_write(32'h100, 32'h00AA_0000, 4'b0100);
    do_read(32'h100, d);
    checks++; if (d !== 32'h11AA_3344) begin failures++; $display("FAIL lane_merge got=%h exp=%h", d, 32'h11AA_3344); end
    do_write(32'h100, 32'hFFFF_FFFF, 4'b0000);
    do_read(32'h100, d);
    checks++; if (d !== 32'h11AA_3344) begin failures++; $display("FAIL sel_zero got=%h exp=%h", d, 32'h11AA_3344); end
    @(negedge clk);
    ce = 1'b1; we = 1'b1; sel = 4'h0; addr = 32'h100; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL read_during_we got=%h exp=0", rdata); end
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic test_alias();
    logic [31:0] d;
    do_write(32'h0, 32'hA5A5_A5A5, 4'hF);
    do_write(32'(4 << AW), 32'h5A5A_5A5A, 4'hF);
    do_read(32'h0, d);
    checks++; if (d !== 32'h5A5A_5A5A) begin failures++; $display("FAIL alias got=%h exp=%h", d, 32'h5A5A_5A5A); end
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = 32'h0; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL ce_low_read got=%h exp=0", rdata); end
  endtask

  task automatic test_ram_random();
    logic [31:0] a, d, hi;
    int          idx;
    for (int i = 0; i < 32; i++) do_write(32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 150; n++) begin
      hi  = $urandom;
      if (hi[31:16] == BASE[31:16]) hi[31:16] = 16'h0000;
      idx = $urandom_range(0, 31);
      a   = (hi & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        do_read(a, d);
        checks++;
        if (d !== mem_m[idx]) begin failures++; $display("FAIL ram_rand idx=%0d got=%h exp=%h", idx, d, mem_m[idx]); end
      end
    end
  endtask

  task automatic test_gpio();
    logic [31:0] d, v;
    logic [3:0]  s;
    do_write(BASE, 32'h0000_BEEF, 4'hF);
    checks++; if (gpio !== 16'hBEEF) begin failures++; $display("FAIL gpio_write got=%h exp=%h", gpio, 16'hBEEF); end
    do_write(BASE, 32'h0, 4'b0011);
    checks++; if (gpio !== 16'hBEEF) begin failures++; $display("FAIL gpio_partial got=%h exp=%h", gpio, 16'hBEEF); end
    for (int n = 0; n < 12; n++) begin
      v = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
      do_write(BASE, v, s);
      checks++; if (gpio !== gpio_m) begin failures++; $display("FAIL gpio_rand got=%h exp=%h", gpio, gpio_m); end
      do_read(BASE, d);
      checks++; if (d !== {16'h0, gpio_m}) begin failures++; $display("FAIL gpio_read got=%h exp=%h", d, {16'h0, gpio_m}); end
    end
    do_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    do_read(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    do_read(BASE + 32'h2, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unaligned_off got=%h exp=0", d); end
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    logic [31:0] d;
    do_write(BASE + 32'h4, 32'd1000, 4'hF);
    do_read(BASE + 32'h4, d);
    checks++; if (d !== count_model()) begin failures++; $display("FAIL count_read got=%h exp=%h", d, count_model()); end
    do_write(BASE + 32'h8, 32'd20, 4'hF);
    do_write(BASE + 32'h4, 32'd15, 4'hF);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_k0 got=%b exp=0", irq); end
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early k=%0d got=%b exp=0", k, irq); end
    end
    // Count is 20 this cycle: a W1C landing now loses to the match.
    ce = 1'b1; we = 1'b1; addr = BASE + 32'hC; wdata = 32'h1; sel = 4'hF;
    tick(1);
    ce = 1'b0; we = 1'b0;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_k6 got=%b exp=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_held got=%b exp=1", irq); end
    do_read(BASE + 32'hC, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL status_read got=%h exp=1", d); end
    do_write(BASE + 32'hC, 32'h1, 4'hF);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c got=%b exp=0", irq); end
    // Second match, then cleared by rewriting COMPARE.
    do_write(BASE + 32'h4, 32'd100, 4'hF);
    do_write(BASE + 32'h8, 32'd102, 4'hF);
    tick(2);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_match2 got=%b exp=1", irq); end
    do_write(BASE + 32'h8, 32'd5, 4'hF);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL compare_clear got=%b exp=0", irq); end
    // Wrap with COMPARE=0 never matches.
    do_write(BASE + 32'h8, 32'h0, 4'hF);
    do_write(BASE + 32'h4, 32'hFFFF_FFFE, 4'hF);
    do_read(BASE + 32'h4, d);
    checks++; if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap0 got=%h exp=%h", d, 32'hFFFF_FFFE); end
    tick(1);
    do_read(BASE + 32'h4, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap1 got=%h exp=%h", d, 32'hFFFF_FFFF); end
    tick(1);
    do_read(BASE + 32'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL wrap2 got=%h exp=0", d); end
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL compare_zero k=%0d got=%b exp=0", k, irq); end
    end
    do_read(BASE + 32'h4, d);
    checks++; if (d !== count_model()) begin failures++; $display("FAIL count_model got=%h exp=%h", d, count_model()); end
  endtask
`else
  task automatic test_timer_disabled();
    logic [31:0] d;
    do_write(BASE + 32'h4, 32'd1234, 4'hF);
    do_write(BASE + 32'h8, 32'd3, 4'hF);
    do_read(BASE + 32'h4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL count_disabled got=%h exp=0", d); end
    do_read(BASE + 32'h8, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL compare_disabled got=%h exp=0", d); end
    do_read(BASE + 32'hC, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL status_disabled got=%h exp=0", d); end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled k=%0d got=%b exp=0", k, irq); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    do_write(BASE, 32'h0000_1234, 4'hF);
`ifdef MMIO_TIMER_EN
    do_write(BASE + 32'h4, 32'd50, 4'hF);
    do_write(BASE + 32'h8, 32'd51, 4'hF);
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
`endif
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'hF; #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL read_in_reset got=%h exp=0", rdata); end
    we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick(1);
    rst = 1'b0; ce = 1'b0; we = 1'b0;
    gpio_m = 16'h0; cnt_base = 32'h0; cnt_cyc = cyc;
    checks++; if (gpio !== 16'h0) begin failures++; $display("FAIL post_reset_gpio got=%h exp=0", gpio); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_irq got=%b exp=0", irq); end
    do_read(32'h100, d);
    checks++; if (d !== mem_m[64]) begin failures++; $display("FAIL ram_retained got=%h exp=%h", d, mem_m[64]); end
    do_read(BASE + 32'h4, d);
`ifdef MMIO_TIMER_EN
    checks++; if (d !== count_model()) begin failures++; $display("FAIL post_reset_count got=%h exp=%h", d, count_model()); end
`else
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_reset_count got=%h exp=0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_alias();
    test_ram_random();
    test_gpio();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_timer_disabled();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
